// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - multi-channel input debouncer with edge and hold/auto-repeat pulses
// Reset is active-high on rst_n; every register, including the synchroniser, resets to its idle value.
module debounce_multi #(
  parameter int               WIDTH          = 4,
  parameter int               CNT_W          = 16,
  parameter int               DEBOUNCE_DELAY = 10000,
  parameter int               SYNC_STAGES    = 2,
  parameter logic [WIDTH-1:0] INIT_VALUE     = {WIDTH{1'b0}},
  parameter int               HOLD_DELAY     = 50000,
  parameter bit               HOLD_REPEAT    = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] hold_o,
  output logic             any_evt_o
);

  localparam logic [CNT_W-1:0] LP_DB_TERM   = CNT_W'(DEBOUNCE_DELAY - 1);
  localparam logic [CNT_W-1:0] LP_HOLD_TERM = CNT_W'(HOLD_DELAY - 1);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] w_s;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int j = 0; j < SYNC_STAGES; j++) begin
        r_sync[j] <= INIT_VALUE;
      end
    end else begin
      r_sync[0] <= data_i;
      for (int j = 1; j < SYNC_STAGES; j++) begin
        r_sync[j] <= r_sync[j-1];
      end
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hcnt;
    logic             r_data;
    logic             r_rise;
    logic             r_fall;
    logic             r_hold;
    logic             r_hold_done;
    logic             w_upd;
    logic             w_hold_hit;

    assign w_upd      = (w_s[g] != r_data) && (r_cnt == LP_DB_TERM);
    // While high, an update can only be a fall, and a fall beats the hold terminal count.
    assign w_hold_hit = r_data && !w_upd && !r_hold_done && (r_hcnt == LP_HOLD_TERM);

    always_ff @(posedge clk) begin
      if (rst_n) begin
        r_cnt       <= '0;
        r_hcnt      <= '0;
        r_data      <= INIT_VALUE[g];
        r_rise      <= 1'b0;
        r_fall      <= 1'b0;
        r_hold      <= 1'b0;
        r_hold_done <= 1'b0;
      end else begin
        r_rise <= w_upd && w_s[g];
        r_fall <= w_upd && !w_s[g];
        r_hold <= w_hold_hit;

        if (w_s[g] == r_data) begin
          r_cnt <= '0;
        end else if (r_cnt == LP_DB_TERM) begin
          r_data <= w_s[g];
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end

        if (!r_data || w_upd) begin
          r_hcnt      <= '0;
          r_hold_done <= 1'b0;
        end else if (r_hcnt == LP_HOLD_TERM) begin
          // Single-shot mode parks at the terminal count and remembers it already fired.
          if (HOLD_REPEAT) begin
            r_hcnt <= '0;
          end else begin
            r_hold_done <= 1'b1;
          end
        end else begin
          r_hcnt <= r_hcnt + 1'b1;
        end
      end
    end

    assign data_o[g] = r_data;
    assign rise_o[g] = r_rise;
    assign fall_o[g] = r_fall;
    assign hold_o[g] = r_hold;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      any_evt_o <= 1'b0;
    end else begin
      any_evt_o <= |(rise_o | fall_o | hold_o);
    end
  end

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - bench for debounce_multi against a sample-history reference model
// Four instances with different parameters share one stimulus stream.
module tb_debounce_multi;

  localparam int NI = 4;

  int          p_dd   [NI] = '{4, 4, 4, 1};
  int          p_hd   [NI] = '{50000, 8, 8, 3};
  int          p_rep  [NI] = '{0, 1, 0, 1};
  int          p_sync [NI] = '{2, 2, 2, 3};
  logic [3:0]  p_init [NI] = '{4'h0, 4'h0, 4'hA, 4'h5};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] data_i = 4'h0;

  logic [3:0] d_o [NI];
  logic [3:0] r_o [NI];
  logic [3:0] f_o [NI];
  logic [3:0] h_o [NI];
  logic       a_o [NI];

  always #5 clk = ~clk;

  debounce_multi #(.WIDTH(4), .CNT_W(16), .DEBOUNCE_DELAY(4), .SYNC_STAGES(2),
                   .INIT_VALUE(4'h0), .HOLD_DELAY(50000), .HOLD_REPEAT(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .data_o(d_o[0]), .rise_o(r_o[0]),
    .fall_o(f_o[0]), .hold_o(h_o[0]), .any_evt_o(a_o[0]));

  debounce_multi #(.WIDTH(4), .CNT_W(16), .DEBOUNCE_DELAY(4), .SYNC_STAGES(2),
                   .INIT_VALUE(4'h0), .HOLD_DELAY(8), .HOLD_REPEAT(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .data_o(d_o[1]), .rise_o(r_o[1]),
    .fall_o(f_o[1]), .hold_o(h_o[1]), .any_evt_o(a_o[1]));

  debounce_multi #(.WIDTH(4), .CNT_W(16), .DEBOUNCE_DELAY(4), .SYNC_STAGES(2),
                   .INIT_VALUE(4'hA), .HOLD_DELAY(8), .HOLD_REPEAT(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .data_o(d_o[2]), .rise_o(r_o[2]),
    .fall_o(f_o[2]), .hold_o(h_o[2]), .any_evt_o(a_o[2]));

  debounce_multi #(.WIDTH(4), .CNT_W(8), .DEBOUNCE_DELAY(1), .SYNC_STAGES(3),
                   .INIT_VALUE(4'h5), .HOLD_DELAY(3), .HOLD_REPEAT(1'b1)) u3 (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .data_o(d_o[3]), .rise_o(r_o[3]),
    .fall_o(f_o[3]), .hold_o(h_o[3]), .any_evt_o(a_o[3]));

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: data_i history since the last reset; s at an edge is the input
  // SYNC edges earlier, and a channel flips once its last DD s samples all disagree with it.
  logic [3:0] hist [$];
  int         ns;
  logic [3:0] m_data [NI];
  logic [3:0] m_rise [NI];
  logic [3:0] m_fall [NI];
  logic [3:0] m_hold [NI];
  logic       m_any  [NI];
  int         m_age  [NI][4];
  logic [3:0] nd, mr, mf, mh, sv;
  bit         stable;

  function automatic logic [3:0] s_at(input int n, input int e);
    if (e <= p_sync[n]) return p_init[n];
    return hist[e - p_sync[n] - 1];
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      hist.delete();
      ns = 0;
      for (int n = 0; n < NI; n++) begin
        m_data[n] = p_init[n];
        m_rise[n] = 4'h0;
        m_fall[n] = 4'h0;
        m_hold[n] = 4'h0;
        m_any[n]  = 1'b0;
        for (int c = 0; c < 4; c++) m_age[n][c] = 0;
      end
    end else begin
      hist.push_back(data_i);
      ns++;
      for (int n = 0; n < NI; n++) begin
        nd = m_data[n];
        mr = 4'h0;
        mf = 4'h0;
        mh = 4'h0;
        for (int c = 0; c < 4; c++) begin
          stable = (ns >= p_dd[n]);
          for (int t = 0; t < p_dd[n]; t++) begin
            sv = s_at(n, ns - t);
            if (sv[c] == m_data[n][c]) stable = 1'b0;
          end
          if (stable) begin
            nd[c] = ~m_data[n][c];
            mr[c] = nd[c];
            mf[c] = ~nd[c];
          end
          if (m_data[n][c] && !mf[c]) begin
            m_age[n][c]++;
            mh[c] = (p_rep[n] != 0) ? (m_age[n][c] % p_hd[n] == 0) : (m_age[n][c] == p_hd[n]);
          end else begin
            m_age[n][c] = 0;
          end
        end
        m_any[n]  = |(m_rise[n] | m_fall[n] | m_hold[n]);
        m_data[n] = nd;
        m_rise[n] = mr;
        m_fall[n] = mf;
        m_hold[n] = mh;
      end
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int n = 0; n < NI; n++) begin
        check($sformatf("u%0d.data", n), 32'(d_o[n]), 32'(m_data[n]));
        check($sformatf("u%0d.rise", n), 32'(r_o[n]), 32'(m_rise[n]));
        check($sformatf("u%0d.fall", n), 32'(f_o[n]), 32'(m_fall[n]));
        check($sformatf("u%0d.hold", n), 32'(h_o[n]), 32'(m_hold[n]));
        check($sformatf("u%0d.any", n), 32'(a_o[n]), 32'(m_any[n]));
      end
    end
  end

  int got;
  int hc0, hc1, hc2;

  initial begin
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.u2_data", 32'(d_o[2]), 32'h0000_000A);
    check("rst.u0_rise", 32'(r_o[0]), 32'h0);
    rst_n = 1'b0;
    repeat (10) @(negedge clk);

    // First-press latency: data_o follows on edge k+5.
    data_i = 4'b0001;
    got = -1;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (d_o[0][0]) begin
        got = e;
        break;
      end
    end
    check("lat.edges", 32'(got), 32'd5);
    check("lat.rise", 32'(r_o[0]), 32'h1);
    @(negedge clk);
    check("lat.rise_clr", 32'(r_o[0]), 32'h0);
    check("lat.any", 32'(a_o[0]), 32'h1);

    data_i = 4'b0000;
    repeat (10) @(negedge clk);
    data_i = 4'b0010;
    repeat (3) @(negedge clk);
    data_i = 4'b0000;
    @(negedge clk);
    data_i = 4'b0010;
    repeat (12) @(negedge clk);
    data_i = 4'b1111;
    repeat (20) @(negedge clk);
    data_i = 4'b0000;
    repeat (12) @(negedge clk);

    // Hold channel 2 for 32 cycles after the debounced rise.
    data_i = 4'b0100;
    got = -1;
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);
      if (d_o[1][2]) begin
        got = e;
        break;
      end
    end
    check("hold.rise_seen", 32'(got >= 0), 32'h1);
    hc0 = 0;
    hc1 = 0;
    hc2 = 0;
    for (int e = 0; e < 50; e++) begin
      if (e == 31) data_i = 4'b0000;
      @(negedge clk);
      hc0 += int'(h_o[0][2]);
      hc1 += int'(h_o[1][2]);
      hc2 += int'(h_o[2][2]);
    end
    check("hold.none", 32'(hc0), 32'd0);
    check("hold.repeat", 32'(hc1), 32'd4);
    check("hold.single", 32'(hc2), 32'd1);

    // Reset mid-count discards progress and restores INIT_VALUE without pulses.
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst.data", 32'(d_o[2]), 32'h0000_000A);
    check("midrst.pulses", 32'(r_o[2] | f_o[2] | h_o[2]), 32'h0);
    rst_n = 1'b0;
    got = -1;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (f_o[2] != 4'h0) begin
        got = e;
        break;
      end
    end
    check("midrst.fall_edges", 32'(got), 32'd5);
    check("midrst.fall_bits", 32'(f_o[2]), 32'h0000_000A);

    for (int i = 0; i < 60; i++) begin
      data_i = data_i ^ 4'($urandom);
      if ($urandom_range(0, 19) == 0) rst_n = 1'b1;
      repeat ($urandom_range(1, 14)) @(negedge clk);
      rst_n = 1'b0;
    end
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
